systolic_result_collector: RTL and testbench
============================================

// Module: systolic_result_collector
// PURPOSE
//  Consumer-side end of the systolic_array output interface. Captures the N_SIZE result rows
//  that the array streams out (valid_out + matrix_c_out, one row per cycle) into a local
//  N_SIZE x N_SIZE buffer. Then drains the full matrix one element per cycle over a
//  valid/ready read port, in row-major order. Sits between systolic_array and the
//  result-writeback/host logic.
// PARAMETERS
//  DATAWIDTH  16  operand width of the array; result elements are 2*DATAWIDTH bits
//  N_SIZE     5   matrix dimension; rows per capture and elements per row
//  (IW = $clog2(N_SIZE), minimum 1)
// PORTS
//  clk          in   1             rising-edge clock
//  rst          in   1             synchronous, active-high reset
//  valid_in     in   1             row strobe; connects to systolic_array valid_out
//  matrix_c_in  in   [N_SIZE] x 2*DATAWIDTH   current result row; element j = column j
//  rd_valid     out  1             rd_data holds a valid element
//  rd_ready     in   1             consumer accepts the element
//  rd_data      out  2*DATAWIDTH   element C[rd_row][rd_col]
//  rd_row       out  IW            row index of rd_data
//  rd_col       out  IW            column index of rd_data
//  rd_last      out  1             high with rd_valid on element (N_SIZE-1, N_SIZE-1)
//  busy         out  1             high while in DRAIN
//  overflow     out  1             sticky; a row arrived while in DRAIN and was dropped
// BEHAVIOUR
//  Reset:
//  - rst is sampled on posedge clk; it has priority over all other inputs.
//  - rst forces state=COLLECT and clears wr_row, rd_row, rd_col to 0.
//  - All outputs reset to 0. Buffer contents are not cleared.
//  FSM states COLLECT and DRAIN.
//  COLLECT:
//  - On each posedge with valid_in=1, buffer[wr_row][j] <= matrix_c_in[j] for all j, and
//    wr_row increments.
//  - Gaps in valid_in are allowed; wr_row advances only on valid_in.
//  - When the row captured is wr_row==N_SIZE-1, the next state is DRAIN and wr_row wraps to 0.
//  - rd_valid=0 and busy=0 in this state.
//  DRAIN:
//  - rd_valid=1 and busy=1, starting in the cycle after the posedge that captured the last
//    row. Latency from the last valid_in edge to rd_valid high is 1 cycle.
//  - rd_data = buffer[rd_row][rd_col]. It is stable while rd_valid & !rd_ready.
//  - Handshake: a transfer occurs on a posedge with rd_valid & rd_ready. On transfer,
//    rd_col increments. At N_SIZE-1, rd_col wraps to 0 and rd_row increments.
//  - rd_last = rd_valid & (rd_row==N_SIZE-1) & (rd_col==N_SIZE-1).
//  - A transfer with rd_last=1 returns the FSM to COLLECT with rd_row=rd_col=0.
//    rd_valid is low in the next cycle, and a valid_in in that same cycle is captured as row 0.
//  - valid_in=1 while in DRAIN: the row is dropped, overflow <= 1, and the buffer and read
//    sequence are not affected. overflow clears only on rst.
//  - While rd_valid=0, rd_data, rd_row, rd_col and rd_last are driven 0.
//  - Reset mid-capture or mid-drain abandons the partial matrix.
//  - Arithmetic: none on data; elements pass through unmodified at 2*DATAWIDTH bits.
//    Index counters never exceed N_SIZE-1.
// TESTING
//  1. Hold rst=1 for 3 cycles -> rd_valid, rd_data, rd_row, rd_col, rd_last, busy and
//     overflow are all 0.
//  2. Drive 5 consecutive valid_in rows with all elements=5, rd_ready=1 ->
//     - rd_valid rises 1 cycle after the 5th row.
//     - 25 transfers of value 5 arrive in order (0,0),(0,1)..(4,4).
//     - rd_last is high only on the 25th transfer; busy=0 the cycle after.
//  3. Drive rows with C[r][j]=10*r+j, with one idle cycle between rows, and toggle rd_ready
//     every other cycle -> the read sequence is 0,1,2,3,4,10,..,44 row-major, and
//     rd_data/rd_row/rd_col hold steady on stalled cycles.
//  4. Pulse valid_in with all elements=99 during DRAIN -> overflow=1 and stays 1. The drained
//     data is unchanged (no 99 appears); overflow clears only on rst.
//  5. Assert rst after 3 captured rows, then send 5 new rows of value 7 -> exactly 25 reads
//     of 7; none of the pre-reset data appears.
//  6. Start a second 5-row burst in the cycle after the rd_last transfer -> the second
//     matrix is fully captured and drained correctly, and overflow=0.

Source files
------------

// File: rtl/systolic_result_collector.sv
// Captures N_SIZE result rows streamed out of the systolic array, then drains
// the buffered matrix one element per cycle, row-major, over a valid/ready port.
module systolic_result_collector #(
    parameter int DATAWIDTH = 16,
    parameter int N_SIZE    = 5,
    localparam int IW       = (N_SIZE > 1) ? $clog2(N_SIZE) : 1,
    localparam int EW       = 2 * DATAWIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    input  logic [N_SIZE-1:0][EW-1:0]  matrix_c_in,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [EW-1:0]              rd_data,
    output logic [IW-1:0]              rd_row,
    output logic [IW-1:0]              rd_col,
    output logic                       rd_last,
    output logic                       busy,
    output logic                       overflow
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N_SIZE - 1);

    typedef enum logic {
        COLLECT,
        DRAIN
    } state_t;

    state_t        state;
    logic [IW-1:0] wr_row;
    logic [IW-1:0] rd_row_q;
    logic [IW-1:0] rd_col_q;
    logic          ovf_q;
    logic          capture;
    logic          at_last;
    logic          draining;

    logic [EW-1:0] buffer [N_SIZE][N_SIZE];

    assign draining = (state == DRAIN);
    assign capture  = (state == COLLECT) && valid_in;
    assign at_last  = (rd_row_q == LAST_IDX) && (rd_col_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= COLLECT;
            wr_row   <= '0;
            rd_row_q <= '0;
            rd_col_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            unique case (state)
                COLLECT: begin
                    if (valid_in) begin
                        if (wr_row == LAST_IDX) begin
                            wr_row <= '0;
                            state  <= DRAIN;
                        end else begin
                            wr_row <= wr_row + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Rows arriving while draining are dropped, not queued.
                    if (valid_in) begin
                        ovf_q <= 1'b1;
                    end
                    if (rd_ready) begin
                        if (at_last) begin
                            state    <= COLLECT;
                            rd_row_q <= '0;
                            rd_col_q <= '0;
                        end else if (rd_col_q == LAST_IDX) begin
                            rd_col_q <= '0;
                            rd_row_q <= rd_row_q + 1'b1;
                        end else begin
                            rd_col_q <= rd_col_q + 1'b1;
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && capture) begin
            for (int j = 0; j < N_SIZE; j++) begin
                buffer[wr_row][j] <= matrix_c_in[j];
            end
        end
    end

    assign rd_valid = draining;
    assign busy     = draining;
    assign overflow = ovf_q;
    assign rd_data  = draining ? buffer[rd_row_q][rd_col_q] : '0;
    assign rd_row   = draining ? rd_row_q : '0;
    assign rd_col   = draining ? rd_col_q : '0;
    assign rd_last  = draining && at_last;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Self-checking bench for systolic_result_collector: vector table of capture/drain
// scenarios with a per-element scoreboard, plus reset and back-to-back sequences.
module tb_systolic_result_collector;

    localparam int DW = 16;
    localparam int N  = 5;
    localparam int IW = 3;
    localparam int EW = 2 * DW;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    valid_in;
    logic [N-1:0][EW-1:0]    matrix_c_in;
    logic                    rd_valid;
    logic                    rd_ready;
    logic [EW-1:0]           rd_data;
    logic [IW-1:0]           rd_row;
    logic [IW-1:0]           rd_col;
    logic                    rd_last;
    logic                    busy;
    logic                    overflow;

    systolic_result_collector #(
        .DATAWIDTH(DW),
        .N_SIZE   (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .matrix_c_in(matrix_c_in),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_last    (rd_last),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [EW-1:0] data;
        int            row;
        int            col;
        bit            last;
    } exp_t;

    exp_t sbq[$];

    typedef struct {
        int mode;
        int base;
        int gap;
        int rmode;
        bit ovf;
        int exp_first;
        int exp_final;
        int exp_sum;
        bit exp_ovf;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] elem(input int mode, input int base,
                                           input int r, input int j);
        if (mode == 0) return EW'(base);
        return EW'(base + 10 * r + j);
    endfunction

    task automatic send_matrix(input int mode, input int base, input int gap,
                               input int nrows, input bit push);
        exp_t e;
        for (int r = 0; r < nrows; r++) begin
            valid_in = 1'b1;
            for (int j = 0; j < N; j++) begin
                matrix_c_in[j] = elem(mode, base, r, j);
                if (push) begin
                    e.data = elem(mode, base, r, j);
                    e.row  = r;
                    e.col  = j;
                    e.last = (r == N - 1) && (j == N - 1);
                    sbq.push_back(e);
                end
            end
            @(negedge clk);
            chk("collect_rd_valid", rd_valid, 0);
            chk("collect_busy", busy, 0);
            @(posedge clk);
            #1;
            valid_in    = 1'b0;
            matrix_c_in = '0;
            if (r < N - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    chk("gap_rd_valid", rd_valid, 0);
                    @(posedge clk);
                    #1;
                end
            end
        end
        if (nrows == N) begin
            @(negedge clk);
            chk("drain_latency_valid", rd_valid, 1);
            chk("drain_latency_busy", busy, 1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int rmode, input bit ovf, output int n,
                         output longint sum, output int first, output int final_v);
        exp_t e;
        int   cyc;
        bit   done;
        n       = 0;
        sum     = 0;
        first   = -1;
        final_v = -1;
        cyc     = 0;
        done    = 1'b0;
        while (!done && cyc < 300) begin
            case (rmode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (cyc % 2 == 1);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            if (ovf && cyc == 2) begin
                valid_in = 1'b1;
                for (int j = 0; j < N; j++) matrix_c_in[j] = EW'(99);
            end else begin
                valid_in    = 1'b0;
                matrix_c_in = '0;
            end
            @(negedge clk);
            if (!rd_valid) begin
                chk("drain_rd_valid", rd_valid, 1);
            end else if (sbq.size() == 0) begin
                chk("scoreboard_empty", sbq.size(), 1);
            end else begin
                e = sbq[0];
                chk("rd_data", rd_data, e.data);
                chk("rd_row", rd_row, e.row);
                chk("rd_col", rd_col, e.col);
                chk("rd_last", rd_last, e.last);
                if (rd_ready) begin
                    void'(sbq.pop_front());
                    n++;
                    sum += longint'(rd_data);
                    if (n == 1) first = int'(rd_data);
                    final_v = int'(rd_data);
                    if (e.last) done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        rd_ready    = 1'b0;
        valid_in    = 1'b0;
        matrix_c_in = '0;
        if (!done) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        int     n;
        longint sum;
        int     first;
        int     fin;

        vecs[0] = '{0,   5, 0, 0, 1'b0,   5,   5,  125, 1'b0};
        vecs[1] = '{1,   0, 1, 1, 1'b0,   0,  44,  550, 1'b0};
        vecs[2] = '{1, 100, 0, 2, 1'b0, 100, 144, 3050, 1'b0};
        vecs[3] = '{0,   3, 0, 0, 1'b1,   3,   3,   75, 1'b1};

        rst         = 1'b1;
        valid_in    = 1'b0;
        rd_ready    = 1'b0;
        matrix_c_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_rd_data", rd_data, 0);
        chk("reset_rd_row", rd_row, 0);
        chk("reset_rd_col", rd_col, 0);
        chk("reset_rd_last", rd_last, 0);
        chk("reset_busy", busy, 0);
        chk("reset_overflow", overflow, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 4; v++) begin
            send_matrix(vecs[v].mode, vecs[v].base, vecs[v].gap, N, 1'b1);
            drain(vecs[v].rmode, vecs[v].ovf, n, sum, first, fin);
            chk("vec_count", n, N * N);
            chk("vec_first", first, vecs[v].exp_first);
            chk("vec_final", fin, vecs[v].exp_final);
            chk("vec_sum", sum, vecs[v].exp_sum);
            @(negedge clk);
            chk("vec_idle_busy", busy, 0);
            chk("vec_idle_valid", rd_valid, 0);
            chk("vec_overflow", overflow, vecs[v].exp_ovf);
            @(posedge clk);
            #1;
        end

        // Overflow is sticky across a further idle stretch.
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("overflow_sticky", overflow, 1);
        @(posedge clk);
        #1;

        // Reset after a partial capture abandons those rows.
        send_matrix(0, 1, 0, 3, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_overflow", overflow, 0);
        chk("midreset_busy", busy, 0);
        @(posedge clk);
        #1;
        send_matrix(0, 7, 0, N, 1'b1);
        drain(0, 1'b0, n, sum, first, fin);
        chk("midreset_count", n, N * N);
        chk("midreset_sum", sum, 175);

        // Second burst begins in the cycle right after the rd_last transfer.
        send_matrix(0, 8, 0, N, 1'b1);
        drain(0, 1'b0, n, sum, first, fin);
        chk("b2b_first_sum", sum, 200);
        send_matrix(1, 200, 0, N, 1'b1);
        drain(2, 1'b0, n, sum, first, fin);
        chk("b2b_count", n, N * N);
        chk("b2b_sum", sum, 5550);
        chk("b2b_final", fin, 244);
        @(negedge clk);
        chk("b2b_overflow", overflow, 0);
        chk("b2b_busy", busy, 0);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
